// File: rtl/uni_sr_pkg.sv
// Shared constants for the universal shift register: mode codes, FSM states and burst directions.
package uni_sr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_SHR   = 3'd1,
        MODE_SHL   = 3'd2,
        MODE_LOAD  = 3'd3,
        MODE_ROR   = 3'd4,
        MODE_ROL   = 3'd5,
        MODE_ASR   = 3'd6,
        MODE_BURST = 3'd7
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/uni_sr_burst_ctr.sv
// Burst sequencer: accepts a counted burst, drives the shift enable and latched direction,
// and produces busy plus a one-cycle done pulse.
//
// state | meaning
// IDLE  | mode codes act on the register; MODE_BURST is accepted here
// BURST | one shift per edge in the latched direction until the counter empties
module uni_sr_burst_ctr
    import uni_sr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             burst_dir,
    output logic             shift_en,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    state_e           state;
    logic [CNT_W-1:0] cnt;

    assign shift_en = (state == BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dir   <= DIR_RIGHT;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mode == MODE_BURST) begin
                        // A zero-length burst completes at the accept edge itself.
                        if (burst_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            cnt   <= burst_len;
                            dir   <= burst_dir;
                            busy  <= 1'b1;
                            state <= BURST;
                        end
                    end
                end
                BURST: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uni_shift_reg_p.sv
// Parametrised universal shift register with counted burst shifting.
// Rotate modes are built only when UNI_SHIFT_REG_P_ROTATE_EN is defined; otherwise they hold.
module uni_shift_reg_p
    import uni_sr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic             sl,
    input  logic             sr,
    input  logic [WIDTH-1:0] par_in,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             burst_dir,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    logic shift_en;
    logic dir;

    uni_sr_burst_ctr #(.CNT_W(CNT_W)) u_burst_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .burst_len (burst_len),
        .burst_dir (burst_dir),
        .shift_en  (shift_en),
        .dir       (dir),
        .busy      (busy),
        .done      (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_out <= '0;
            ser_out <= 1'b0;
        end else if (shift_en) begin
            // Burst shifts take priority; mode is ignored until the burst ends.
            if (dir == DIR_LEFT) begin
                par_out <= {par_out[WIDTH-2:0], sr};
                ser_out <= par_out[WIDTH-1];
            end else begin
                par_out <= {sl, par_out[WIDTH-1:1]};
                ser_out <= par_out[0];
            end
        end else begin
            case (mode)
                MODE_SHR: begin
                    par_out <= {sl, par_out[WIDTH-1:1]};
                    ser_out <= par_out[0];
                end
                MODE_SHL: begin
                    par_out <= {par_out[WIDTH-2:0], sr};
                    ser_out <= par_out[WIDTH-1];
                end
                MODE_LOAD: par_out <= par_in;
`ifdef UNI_SHIFT_REG_P_ROTATE_EN
                MODE_ROR: begin
                    par_out <= {par_out[0], par_out[WIDTH-1:1]};
                    ser_out <= par_out[0];
                end
                MODE_ROL: begin
                    par_out <= {par_out[WIDTH-2:0], par_out[WIDTH-1]};
                    ser_out <= par_out[WIDTH-1];
                end
`endif
                MODE_ASR: begin
                    par_out <= {par_out[WIDTH-1], par_out[WIDTH-1:1]};
                    ser_out <= par_out[0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uni_shift_reg_p.sv
// Self-checking bench for uni_shift_reg_p: directed scenarios followed by random stimulus
// compared against an arithmetic reference model.
module tb_uni_shift_reg_p;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       mode;
    logic             sl;
    logic             sr;
    logic [W-1:0]     par_in;
    logic [CNT_W-1:0] burst_len;
    logic             burst_dir;
    logic [W-1:0]     par_out;
    logic             ser_out;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int unsigned m_val;
    int unsigned m_ser;
    int          m_rem;
    int unsigned m_dir;
    int unsigned m_busy;
    int unsigned m_done;

    uni_shift_reg_p #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sl        (sl),
        .sr        (sr),
        .par_in    (par_in),
        .burst_len (burst_len),
        .burst_dir (burst_dir),
        .par_out   (par_out),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op(input logic [2:0] m);
        mode = m;
        cyc();
    endtask

    task automatic model_step();
        int unsigned mask;
        int unsigned msb;
        mask   = (1 << W) - 1;
        msb    = 1 << (W - 1);
        m_done = 0;
        if (m_rem > 0) begin
            if (m_dir == 1) begin
                m_ser = (m_val >> (W - 1)) & 1;
                m_val = ((m_val << 1) | sr) & mask;
            end else begin
                m_ser = m_val & 1;
                m_val = (m_val >> 1) | (sl ? msb : 0);
            end
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end else begin
            case (mode)
                3'd1: begin
                    m_ser = m_val & 1;
                    m_val = (m_val >> 1) | (sl ? msb : 0);
                end
                3'd2: begin
                    m_ser = (m_val >> (W - 1)) & 1;
                    m_val = ((m_val << 1) | sr) & mask;
                end
                3'd3: m_val = par_in;
`ifdef UNI_SHIFT_REG_P_ROTATE_EN
                3'd4: begin
                    m_ser = m_val & 1;
                    m_val = (m_val >> 1) | ((m_val & 1) ? msb : 0);
                end
                3'd5: begin
                    m_ser = (m_val >> (W - 1)) & 1;
                    m_val = ((m_val << 1) | m_ser) & mask;
                end
`endif
                3'd6: begin
                    m_ser = m_val & 1;
                    m_val = (m_val >> 1) | (m_val & msb);
                end
                3'd7: begin
                    if (burst_len == 0) begin
                        m_done = 1;
                    end else begin
                        m_rem  = burst_len;
                        m_dir  = burst_dir;
                        m_busy = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 3'd0;
        sl        = 1'b0;
        sr        = 1'b0;
        par_in    = '0;
        burst_len = '0;
        burst_dir = 1'b0;
        #12;
        chk("rst_par", 32'(par_out), 0);
        chk("rst_ser", 32'(ser_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        par_in = 8'hA5; op(3'd3);
        sl = 1'b1; op(3'd1);
        chk("shr_par", 32'(par_out), 32'hD2);
        chk("shr_ser", 32'(ser_out), 1);
        op(3'd3);
        sr = 1'b0; op(3'd2);
        chk("shl_par", 32'(par_out), 32'h4A);
        chk("shl_ser", 32'(ser_out), 1);

        par_in = 8'h81; op(3'd3);
        op(3'd6);
        chk("asr1_par", 32'(par_out), 32'hC0);
        chk("asr1_ser", 32'(ser_out), 1);
        sl = 1'b0; op(3'd6);
        chk("asr2_par", 32'(par_out), 32'hE0);
        chk("asr2_ser", 32'(ser_out), 0);

        par_in = 8'h01; op(3'd3);
        op(3'd4);
`ifdef UNI_SHIFT_REG_P_ROTATE_EN
        chk("ror_par", 32'(par_out), 32'h80);
        chk("ror_ser", 32'(ser_out), 1);
`else
        chk("ror_par", 32'(par_out), 32'h01);
        chk("ror_ser", 32'(ser_out), 0);
`endif

        par_in = 8'hF0; op(3'd3);
        burst_len = 4'd4; burst_dir = 1'b0; sl = 1'b0;
        op(3'd7);
        chk("b4_acc_busy", 32'(busy), 1);
        chk("b4_acc_par", 32'(par_out), 32'hF0);
        mode = 3'd2;
        cyc(); chk("b4_s1", 32'(par_out), 32'h78); chk("b4_s1_busy", 32'(busy), 1);
        cyc(); chk("b4_s2", 32'(par_out), 32'h3C); chk("b4_s2_busy", 32'(busy), 1);
        cyc(); chk("b4_s3", 32'(par_out), 32'h1E); chk("b4_s3_busy", 32'(busy), 1);
        cyc(); chk("b4_s4", 32'(par_out), 32'h0F); chk("b4_s4_busy", 32'(busy), 0);
        chk("b4_done", 32'(done), 1);
        op(3'd0);
        chk("b4_done_end", 32'(done), 0);

        burst_len = 4'd0;
        op(3'd7);
        chk("b0_done", 32'(done), 1);
        chk("b0_busy", 32'(busy), 0);
        chk("b0_par", 32'(par_out), 32'h0F);
        op(3'd0);
        chk("b0_done_end", 32'(done), 0);

        par_in = 8'h00; op(3'd3);
        burst_len = 4'd8; burst_dir = 1'b1; sr = 1'b1;
        op(3'd7);
        mode = 3'd0;
        for (int i = 0; i < 8; i++) cyc();
        chk("b8_par", 32'(par_out), 32'hFF);
        chk("b8_done", 32'(done), 1);

        par_in = 8'h5A; op(3'd3);
        burst_len = 4'd4; burst_dir = 1'b0;
        op(3'd7);
        mode = 3'd0;
        cyc();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_par", 32'(par_out), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("abort_no_done", 32'(done), 0);
        end

        m_val = 0; m_ser = 0; m_rem = 0; m_dir = 0; m_busy = 0; m_done = 0;
        for (int i = 0; i < 600; i++) begin
            mode      = 3'($urandom_range(0, 7));
            sl        = 1'($urandom);
            sr        = 1'($urandom);
            par_in    = W'($urandom);
            burst_len = CNT_W'($urandom_range(0, 9));
            burst_dir = 1'($urandom);
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("rnd_par", 32'(par_out), m_val);
            chk("rnd_ser", 32'(ser_out), m_ser);
            chk("rnd_busy", 32'(busy), m_busy);
            chk("rnd_done", 32'(done), m_done);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
